// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the core load/store port: IDLE -> WAIT -> RESP.
// Define MISALIGN_TRAP_EN to flag misaligned accesses and suppress them instead of force-aligning.
module data_mem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             isByte,
  input  logic             isHalf,
  input  logic             isWord,
  input  logic             isUnsigned,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             memReady,
  output logic             busy,
  output logic             misalign
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

  stateT            state, nextState;
  logic [3:0]       waitCnt;
  logic [AW+1:0]    reqAddr;
  logic [WIDTH-1:0] reqWdata;
  logic             reqWrite;
  logic             reqByte;
  logic             reqHalf;
  logic             reqUnsigned;

  logic [WIDTH-1:0] ram [DEPTH];

  logic             accept;
  logic [AW-1:0]    wordIdx;
  logic [1:0]       lane;
  logic [WIDTH-1:0] curWord;
  logic [7:0]       curByte;
  logic [15:0]      curHalf;
  logic [3:0]       byteEn;
  logic [WIDTH-1:0] wrWord;
  logic [WIDTH-1:0] loadVal;
  logic             blocked;

  // Bits above the wrapped word index carry no meaning for this memory.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{addr[WIDTH-1:AW+2], isWord};

  assign accept = (state == IDLE) && (memRead || memWrite);

  // NOTE: state and request registers use non-blocking assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      reqAddr     <= '0;
      reqWdata    <= '0;
      reqWrite    <= 1'b0;
      reqByte     <= 1'b0;
      reqHalf     <= 1'b0;
      reqUnsigned <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        reqAddr     <= addr[AW+1:0];
        reqWdata    <= wdata;
        reqWrite    <= memWrite;
        reqByte     <= isByte;
        reqHalf     <= !isByte && isHalf;
        reqUnsigned <= isUnsigned;
        waitCnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (memRead || memWrite) nextState = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt == 4'd0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign wordIdx = reqAddr[AW+1:2];
  assign lane    = reqAddr[1:0];
  assign curWord = ram[wordIdx];
  assign curByte = curWord[{lane, 3'b000} +: 8];
  assign curHalf = curWord[{lane[1], 4'b0000} +: 16];

  // Lane selection ignores the low address bits a half/word does not use,
  // which is what force-aligns them when the trap is disabled.
  always_comb begin
    byteEn  = 4'b0000;
    wrWord  = '0;
    loadVal = '0;
    if (reqByte) begin
      byteEn[lane] = 1'b1;
      wrWord       = {4{reqWdata[7:0]}};
      loadVal      = {{24{!reqUnsigned && curByte[7]}}, curByte};
    end else if (reqHalf) begin
      byteEn  = lane[1] ? 4'b1100 : 4'b0011;
      wrWord  = {2{reqWdata[15:0]}};
      loadVal = {{16{!reqUnsigned && curHalf[15]}}, curHalf};
    end else begin
      byteEn  = 4'b1111;
      wrWord  = reqWdata;
      loadVal = curWord;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign blocked  = (reqHalf && lane[0]) || (!reqByte && !reqHalf && lane != 2'b00);
  assign misalign = memReady && blocked;
`else
  assign blocked  = 1'b0;
  assign misalign = 1'b0;
`endif

  // NOTE: the RAM array has no reset; clearing it would force a flop-based
  // implementation, and contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (state == RESP && reqWrite && !blocked) begin
      for (int k = 0; k < 4; k++) begin
        if (byteEn[k]) ram[wordIdx][8*k +: 8] <= wrWord[8*k +: 8];
      end
    end
  end

  assign memReady = (state == RESP);
  assign busy     = (state != IDLE);
  assign rdata    = (memReady && !reqWrite && !blocked) ? loadVal : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=1, one at LATENCY=3
// (used for the mid-flight reset abort). Honours MISALIGN_TRAP_EN if defined.
module tb_data_mem_responder;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0;
  logic        isByte = 1'b0, isHalf = 1'b0, isWord = 1'b0, isUnsigned = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        sel = 1'b0;

  logic [31:0] rdataA, rdataB, rdata;
  logic        readyA, readyB, busyA, busyB, misA, misB;
  logic        memReady, busy, misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    string       tag;
  } expT;
  expT expQ[$];

  always #5 clk = ~clk;

  data_mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(LAT_A)) u_dutA (
    .clk(clk), .reset(reset),
    .memRead(memRead && !sel), .memWrite(memWrite && !sel),
    .isByte(isByte), .isHalf(isHalf), .isWord(isWord), .isUnsigned(isUnsigned),
    .addr(addr), .wdata(wdata),
    .rdata(rdataA), .memReady(readyA), .busy(busyA), .misalign(misA)
  );

  data_mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(LAT_B)) u_dutB (
    .clk(clk), .reset(reset),
    .memRead(memRead && sel), .memWrite(memWrite && sel),
    .isByte(isByte), .isHalf(isHalf), .isWord(isWord), .isUnsigned(isUnsigned),
    .addr(addr), .wdata(wdata),
    .rdata(rdataB), .memReady(readyB), .busy(busyB), .misalign(misB)
  );

  assign rdata    = sel ? rdataB : rdataA;
  assign memReady = sel ? readyB : readyA;
  assign busy     = sel ? busyB  : busyA;
  assign misalign = sel ? misB   : misA;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every completion pulse pops one expectation.
  always @(negedge clk) begin
    if (memReady) begin
      expT e;
      if (expQ.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        check({e.tag, "_rdata"}, rdata, e.data);
        check({e.tag, "_mis"}, 32'(misalign), 32'(e.mis));
      end
    end
  end

  task automatic clearInputs();
    memRead = 1'b0; memWrite = 1'b0;
    isByte = 1'b0; isHalf = 1'b0; isWord = 1'b0; isUnsigned = 1'b0;
    addr = '0; wdata = '0;
  endtask

  // Issues one request and holds it through the response edge, so the bench
  // also sees that a held request is neither re-accepted nor restarted.
  task automatic doReq(input string tag, input bit wr, input bit rd,
                       input bit b, input bit h, input bit w, input bit u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] expData, input bit expMis);
    int  n;
    bit  seen;
    int  lat;
    lat = sel ? LAT_B : LAT_A;
    expQ.push_back('{data: expData, mis: expMis, tag: tag});
    @(negedge clk);
    memWrite = wr; memRead = rd;
    isByte = b; isHalf = h; isWord = w; isUnsigned = u;
    addr = a; wdata = wd;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = memReady;
    end
    check({tag, "_latency"}, seen ? n : 99, lat + 1);
    @(posedge clk);
    #1 clearInputs();
    @(negedge clk);
    check({tag, "_no_reaccept"}, 32'(busy), 32'd0);
  endtask

  initial begin
    clearInputs();
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(memReady), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(memReady), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rdata", rdata, 32'd0);
      check("idle_mis", 32'(misalign), 32'd0);
    end

    //    tag          wr rd b  h  w  u  addr      wdata         expected
    doReq("sw_10",     1, 0, 0, 0, 1, 0, 32'h10,  32'hDEADBEEF, 32'h0, 0);
    doReq("lw_10",     0, 1, 0, 0, 1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    doReq("sb_11",     1, 0, 1, 0, 0, 0, 32'h11,  32'hFFFFFF5A, 32'h0, 0);
    doReq("lb_11",     0, 1, 1, 0, 0, 0, 32'h11,  32'h0,        32'h0000005A, 0);
    doReq("lw_10b",    0, 1, 0, 0, 1, 0, 32'h10,  32'h0,        32'hDEAD5AEF, 0);
    doReq("lb_13",     0, 1, 1, 0, 0, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    doReq("lbu_13",    0, 1, 1, 0, 0, 1, 32'h13,  32'h0,        32'h000000DE, 0);
    doReq("lh_12",     0, 1, 0, 1, 0, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 0);
    doReq("lhu_12",    0, 1, 0, 1, 0, 1, 32'h12,  32'h0,        32'h0000DEAD, 0);
    doReq("nosize_10", 0, 1, 0, 0, 0, 0, 32'h10,  32'h0,        32'hDEAD5AEF, 0);
    doReq("bh_prio",   0, 1, 1, 1, 0, 1, 32'h13,  32'h0,        32'h000000DE, 0);
    doReq("sw_lw_20",  1, 1, 0, 0, 1, 0, 32'h20,  32'h00001234, 32'h0, 0);
    doReq("lw_20",     0, 1, 0, 0, 1, 0, 32'h20,  32'h0,        32'h00001234, 0);
    doReq("lw_wrap",   0, 1, 0, 0, 1, 0, 32'h420, 32'h0,        32'h00001234, 0);
    doReq("lw_22",     0, 1, 0, 0, 1, 0, 32'h22,  32'h0,        TRAP ? 32'h0 : 32'h00001234, TRAP);
    doReq("sh_22",     1, 0, 0, 1, 0, 0, 32'h22,  32'hFFFFABCD, 32'h0, 0);
    doReq("lw_20b",    0, 1, 0, 0, 1, 0, 32'h20,  32'h0,        32'hABCD1234, 0);
    doReq("lh_21",     0, 1, 0, 1, 0, 0, 32'h21,  32'h0,        TRAP ? 32'h0 : 32'h00001234, TRAP);
    doReq("sw_21",     1, 0, 0, 0, 1, 0, 32'h21,  32'h11111111, 32'h0, TRAP);
    doReq("lw_20c",    0, 1, 0, 0, 1, 0, 32'h20,  32'h0,        TRAP ? 32'hABCD1234 : 32'h11111111, 0);

    // Mid-flight reset on the LATENCY=3 instance must abort the store.
    sel = 1'b1;
    doReq("sw_30",     1, 0, 0, 0, 1, 0, 32'h30,  32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    memWrite = 1'b1; isWord = 1'b1; addr = 32'h30; wdata = 32'h0BADBEEF;
    @(posedge clk);
    #1 clearInputs();
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(memReady), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_mis", 32'(misalign), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    doReq("lw_30",     0, 1, 0, 0, 1, 0, 32'h30,  32'h0,        32'hCAFEF00D, 0);

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
